serial_rx: RTL
==============

Name: serial_rx

Overview:
- 8N1 UART receiver, the receive-side counterpart of the existing serial transmitter. Runs on the 12 MHz system clock.
- Samples the asynchronous `uart0_rxd` line, reassembles bytes LSB-first and presents them on a one-entry valid/ready output register.
- Reports framing errors and overruns as single-cycle pulses.
- Sits between the board RX pin and consumer logic such as an echo path or command parser.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per bit period (12 MHz / 115200, rounded). Legal range 8..4095.
- HALF_BIT, CLKS_PER_BIT/2, cycle offset from start-edge detection to the start-bit mid-sample.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- rxd  input  1  asynchronous serial line; idle high.
- rx_ready  input  1  consumer accepts rx_data this cycle.
- rx_data  output  8  received byte; stable while rx_valid is high.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_busy  output  1  a frame is in progress (state is not IDLE).
- rx_frame_err  output  1  1-cycle pulse: stop bit sampled low.
- rx_overrun  output  1  1-cycle pulse: completed byte dropped because the holding register was full.

Behaviour:
- Input conditioning:
  - 2-flop synchronizer on rxd, then a 3-bit history of synchronized samples.
  - The bit value at every sample instant is the majority of the last 3 synchronized samples.
  - The edge-detect "previous" register resets to 0, so a line held low through reset never triggers a frame.
- Reset (rst=0 at a clk edge):
  - State IDLE. rx_data=0x00, rx_valid=0, rx_busy=0, rx_frame_err=0, rx_overrun=0.
  - Synchronizer flops = 1; bit counter and cycle counter = 0.
  - Reset asserted mid-frame aborts the frame and discards the partial byte.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - A synchronized 1->0 transition moves to START and clears the cycle counter (call this cycle T0).
- START:
  - At T0+HALF_BIT, take the majority-voted sample.
  - Sample 0: go to DATA with counter cleared.
  - Sample 1: glitch; return to IDLE with no output activity.
- DATA:
  - Sample every CLKS_PER_BIT cycles, i.e. bit i at T0+HALF_BIT+(i+1)*CLKS_PER_BIT for i=0..7.
  - Shift in LSB-first. After bit 7, go to STOP.
- STOP:
  - Sample at T0+HALF_BIT+9*CLKS_PER_BIT.
  - Sample 1: byte complete; go to IDLE in the same transition, so a start edge half a bit later is caught.
  - Sample 0: pulse rx_frame_err for 1 cycle, discard the byte, go to BREAK.
- BREAK:
  - Stay until the synchronized line is 1, then go to IDLE. A break condition therefore yields exactly one rx_frame_err.
- Output handshake:
  - A completed byte loads rx_data and sets rx_valid on the cycle after the stop sample.
  - rx_valid stays high until a cycle with rx_valid & rx_ready; it clears on the next edge.
  - rx_data must not change while rx_valid=1, except on a same-cycle accept-and-load.
  - Byte completes while rx_valid=1 and rx_ready=0: keep the old byte, drop the new one, pulse rx_overrun for 1 cycle.
  - Byte completes while rx_valid=1 and rx_ready=1: old byte consumed, new byte loaded, rx_valid stays 1, no overrun.
  - rx_ready while rx_valid=0 is ignored.
- Latency: from the synchronized start edge to rx_valid is HALF_BIT + 9*CLKS_PER_BIT + 1 cycles, plus 2 cycles of synchronizer delay from the pin.
- Counters:
  - Cycle counter is 12 bits and saturates-free; it is cleared at each sample instant.
  - Bit counter is 3 bits and wraps only at the DATA->STOP exit.
- rx_busy = (state != IDLE).

Test Plan:
- Send 0x55, 8N1, 104 clks/bit, rx_ready held 1 -> rx_data=0x55, rx_valid high exactly 1 cycle, rising 52+936+1 cycles after the synchronized start edge; no error pulses.
- Back-to-back 0xA5 then 0x3C with zero idle between stop and start, rx_ready=1 -> two valid beats, data 0xA5 then 0x3C, in order.
- rxd low for 30 cycles then high -> START aborts at the HALF_BIT sample; no rx_valid, no rx_frame_err; rx_busy returns to 0.
- Frame 0xFF with stop bit forced low, then line held low for 2000 cycles -> single rx_frame_err pulse, no rx_valid, rx_busy=1 until the line returns high, then the next 0x12 frame is received correctly.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11 with rx_valid=1; rx_overrun pulses once at 0x22 completion. Then raise rx_ready -> 0x11 is consumed and rx_valid drops.
- Assert rst=0 during data bit 4 of a 0xC3 frame with rxd still low, release, then send 0x7E -> all outputs 0 during reset; no spurious frame from the held-low line; 0x7E received correctly.

Source files
------------

// File: rtl/serial_rx.sv
// 8N1 UART receiver: majority-voted mid-bit sampling, LSB-first reassembly, one-entry valid/ready holding register.
// Latency: HALF_BIT + 9*CLKS_PER_BIT + 1 cycles from the synchronized start edge (+2 synchronizer cycles from the pin).
// Backpressure: a byte completing while the holding register is full and not being accepted is dropped with an overrun pulse.
module serial_rx #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam logic [11:0] BIT_LAST  = 12'(CLKS_PER_BIT - 1);
  localparam logic [11:0] HALF_LAST = 12'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic [2:0]  hist_q;
  logic        prev_q;
  logic [1:0]  settle_q;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        done;
  logic        maj;
  logic        fall;

  assign maj  = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  assign fall = prev_q & ~sync2_q;

  // The synchronizer comes out of reset holding 1s that are not real line
  // samples; settle_q keeps them out of the edge detector so a line held low
  // through reset is never mistaken for a start edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      hist_q   <= 3'b111;
      prev_q   <= 1'b0;
      settle_q <= 2'b00;
    end else begin
      sync1_q  <= rxd;
      sync2_q  <= sync1_q;
      hist_q   <= {hist_q[1:0], sync2_q};
      prev_q   <= sync2_q & settle_q[1];
      settle_q <= {settle_q[0], 1'b1};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 12'd1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    done      = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = maj ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {maj, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (maj) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (sync2_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Holding register: a same-cycle accept frees the slot for the new byte.
  always_comb begin
    valid_d = valid_q & ~rx_ready;
    data_d  = data_q;
    ovr_d   = 1'b0;
    if (done) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_busy      = (state_q != IDLE);
  assign rx_frame_err = ferr_q;
  assign rx_overrun   = ovr_q;

endmodule
